// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the pc / rom / register_file / alu
// datapath. Each instruction walks FETCH -> DECODE -> EXEC -> WB.
// Build option: define CPU_SEQ_STEP_EN to add a single-step input.
module cpu_sequencer #(
   parameter int CNT_W        = 16,
   parameter int IMEM_TIMEOUT = 15,
   parameter int ALU_OP_W     = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
`ifdef CPU_SEQ_STEP_EN
   input  logic                step,
`endif
   output logic                imem_req,
   input  logic                imem_ready,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_b5,
   output logic                ir_load,
   output logic                alu_src,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                rf_wr_en,
   output logic                pc_en,
   output logic                busy,
   output logic [1:0]          halt_cause,
   output logic [CNT_W-1:0]    instr_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(7);

   // Timeout counter only has to reach IMEM_TIMEOUT.
   localparam int              TO_W    = (IMEM_TIMEOUT < 1) ? 1 : $clog2(IMEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(IMEM_TIMEOUT);

   state_t                state_reg;
   logic [TO_W-1:0]       timeout_cnt_reg;
   logic                  start;
   logic                  is_op;
   logic                  is_op_imm;
   logic                  dec_legal;
   logic                  dec_src;
   logic [ALU_OP_W-1:0]   dec_op;

`ifdef CPU_SEQ_STEP_EN
   // In IDLE a step pulse starts one instruction; WB returns to IDLE because run=0.
   assign start = run | step;
`else
   assign start = run;
`endif

   assign is_op     = (opcode == OPC_OP);
   assign is_op_imm = (opcode == OPC_OP_IMM);

   // The IR is latched on the same edge that ends the accepted FETCH cycle.
   assign ir_load = (state_reg == FETCH) && imem_ready;

   // Instruction decoder: ALU controls plus a legality flag for the current IR.
   always_comb begin
      dec_legal = is_op | is_op_imm;
      dec_src   = is_op_imm;
      dec_op    = ALU_ADD;
      case (funct3)
         3'b000:  dec_op = (is_op && funct7_b5) ? ALU_SUB : ALU_ADD;
         3'b111:  dec_op = ALU_AND;
         3'b110:  dec_op = ALU_OR;
         3'b100:  dec_op = ALU_XOR;
         3'b001:  dec_op = ALU_SLL;
         3'b101:  dec_op = ALU_SRL;
         3'b010:  dec_op = ALU_SLT;
         default: dec_legal = 1'b0;
      endcase
   end

   // Sequencer FSM with registered strobes, status and retire counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         timeout_cnt_reg <= '0;
         imem_req        <= 1'b0;
         alu_src         <= 1'b0;
         alu_op          <= '0;
         rf_wr_en        <= 1'b0;
         pc_en           <= 1'b0;
         busy            <= 1'b0;
         halt_cause      <= 2'b00;
         instr_cnt       <= '0;
      end else begin
         rf_wr_en <= 1'b0;
         pc_en    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg       <= FETCH;
                  imem_req        <= 1'b1;
                  busy            <= 1'b1;
                  timeout_cnt_reg <= '0;
               end
            end
            FETCH: begin
               // A ready arriving on the last allowed cycle still wins.
               if (imem_ready) begin
                  state_reg       <= DECODE;
                  imem_req        <= 1'b0;
                  timeout_cnt_reg <= '0;
               end else if (timeout_cnt_reg == TO_LAST) begin
                  state_reg       <= HALT;
                  imem_req        <= 1'b0;
                  busy            <= 1'b0;
                  halt_cause      <= 2'b10;
                  timeout_cnt_reg <= '0;
               end else begin
                  timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
               end
            end
            DECODE: begin
               if (dec_legal) begin
                  alu_src   <= dec_src;
                  alu_op    <= dec_op;
                  state_reg <= EXEC;
               end else begin
                  state_reg  <= HALT;
                  busy       <= 1'b0;
                  halt_cause <= 2'b01;
               end
            end
            EXEC: begin
               // Strobes are registered so they are high exactly during WB.
               state_reg <= WB;
               rf_wr_en  <= 1'b1;
               pc_en     <= 1'b1;
            end
            WB: begin
               instr_cnt <= instr_cnt + CNT_W'(1);
               if (run) begin
                  state_reg <= FETCH;
                  imem_req  <= 1'b1;
               end else begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end
            end
            HALT: begin
               state_reg <= HALT;
            end
            default: begin
               state_reg <= IDLE;
               imem_req  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed stimulus with a retire scoreboard for cpu_sequencer.
`timescale 1ns/1ps
module tb_cpu_sequencer;

   localparam int CNT_W = 4;
   localparam int TO    = 6;
   localparam int AW    = 3;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;

   typedef struct {
      logic             src;
      logic [AW-1:0]    op;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             imem_ready;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             funct7_b5;
   logic             imem_req;
   logic             ir_load;
   logic             alu_src;
   logic [AW-1:0]    alu_op;
   logic             rf_wr_en;
   logic             pc_en;
   logic             busy;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] instr_cnt;
`ifdef CPU_SEQ_STEP_EN
   logic             step;
`endif

   int               tests = 0;
   int               failed = 0;
   int               cyc = 0;
   int               last_load_cyc = 0;
   int               last_retire_cyc = 0;
   int               last_gap = 0;
   int               load_count = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   exp_t             sb_q[$];

   cpu_sequencer #(.CNT_W(CNT_W), .IMEM_TIMEOUT(TO), .ALU_OP_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
`ifdef CPU_SEQ_STEP_EN
      .step       (step),
`endif
      .imem_req   (imem_req),
      .imem_ready (imem_ready),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7_b5  (funct7_b5),
      .ir_load    (ir_load),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .rf_wr_en   (rf_wr_en),
      .pc_en      (pc_en),
      .busy       (busy),
      .halt_cause (halt_cause),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("[TB] ok   %s = %0h", name, act);
      end
   endtask

   // Monitor: every WB strobe pops one expected retire and compares it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (ir_load) begin
            last_load_cyc = cyc;
            load_count++;
         end
         if (rf_wr_en || pc_en) begin
            if (sb_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL sb_unexpected: retire strobe seen (cnt=%0d), required none", instr_cnt);
            end else begin
               e = sb_q.pop_front();
               $display("[TB] retire cnt=%0d src=%0b op=%0d", instr_cnt, alu_src, alu_op);
               check("sb_alu_src", alu_src, e.src);
               check("sb_alu_op", alu_op, e.op);
               check("sb_cnt", instr_cnt, e.cnt);
               check("sb_strobes", {rf_wr_en, pc_en, busy}, 3'b111);
               check("sb_latency", cyc - last_load_cyc, 3);
               last_gap        = cyc - last_retire_cyc;
               last_retire_cyc = cyc;
            end
         end
      end
   end

   // Wait for the fetch handshake, present the instruction fields, log the expectation.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic legal, input logic esrc, input logic [AW-1:0] eop);
      int n = 0;
      while (!ir_load && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ir_load) begin
         tests++;
         failed++;
         $display("FAIL issue_wait: ir_load=%0b after %0d cycles, required 1", ir_load, n);
      end else begin
         opcode    = op;
         funct3    = f3;
         funct7_b5 = f7;
         if (legal) begin
            sb_q.push_back('{esrc, eop, exp_cnt});
            exp_cnt++;
         end
         @(negedge clk);
      end
   endtask

   // Asynchronous reset applied between clock edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      run        = 1'b0;
      imem_ready = 1'b0;
      rst        = 1'b0;
      #1;
      check("rst_imem_req", imem_req, 0);
      check("rst_ir_load", ir_load, 0);
      check("rst_alu_src", alu_src, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_rf_wr_en", rf_wr_en, 0);
      check("rst_pc_en", pc_en, 0);
      check("rst_busy", busy, 0);
      check("rst_halt_cause", halt_cause, 0);
      check("rst_instr_cnt", instr_cnt, 0);
      exp_cnt = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Wait for the instruction in DECODE to finish through WB and land in IDLE.
   task automatic drain_to_idle();
      run = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_imem_req", imem_req, 0);
      check("idle_instr_cnt", instr_cnt, exp_cnt);
   endtask

   initial begin
      int n;
      int l0;
      int strobes;
      rst        = 1'b0;
      run        = 1'b0;
      imem_ready = 1'b0;
      opcode     = 7'd0;
      funct3     = 3'd0;
      funct7_b5  = 1'b0;
`ifdef CPU_SEQ_STEP_EN
      step       = 1'b0;
`endif
      do_reset();

      // T1/T2: back-to-back zero-wait fetches across the funct3 map.
      run        = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      check("t1_load_latency", ir_load, 1);
      check("t1_req", {imem_req, busy}, 2'b11);
      issue(OPC_IMM, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0);
      issue(OPC_IMM, 3'b111, 1'b0, 1'b1, 1'b1, 3'd2);
      issue(OPC_OP,  3'b000, 1'b1, 1'b1, 1'b0, 3'd1);
      issue(OPC_OP,  3'b111, 1'b0, 1'b1, 1'b0, 3'd2);
      issue(OPC_OP,  3'b110, 1'b0, 1'b1, 1'b0, 3'd3);
      issue(OPC_OP,  3'b100, 1'b0, 1'b1, 1'b0, 3'd4);
      issue(OPC_OP,  3'b001, 1'b0, 1'b1, 1'b0, 3'd5);
      issue(OPC_OP,  3'b101, 1'b0, 1'b1, 1'b0, 3'd6);
      issue(OPC_OP,  3'b010, 1'b0, 1'b1, 1'b0, 3'd7);
      issue(OPC_OP,  3'b000, 1'b0, 1'b1, 1'b0, 3'd0);
      issue(OPC_IMM, 3'b000, 1'b1, 1'b1, 1'b1, 3'd0);
      // T5: run dropped while the last one is in DECODE.
      drain_to_idle();
      check("t1_period", last_gap, 4);

      // T6: counter wraps after 16 retires.
      run = 1'b1;
      for (int i = 0; i < 5; i++) issue(OPC_IMM, 3'b110, 1'b0, 1'b1, 1'b1, 3'd3);
      drain_to_idle();
      check("t6_wrap", instr_cnt, 0);

      // IDLE with run=0 must not fetch even though memory is ready.
      l0 = load_count;
      repeat (5) @(negedge clk);
      check("idle_hold_loads", load_count - l0, 0);
      check("idle_hold_busy", busy, 0);

`ifdef CPU_SEQ_STEP_EN
      // Single step: exactly one instruction, then back to IDLE.
      l0   = load_count;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      issue(OPC_IMM, 3'b101, 1'b0, 1'b1, 1'b1, 3'd6);
      repeat (8) @(negedge clk);
      check("step_loads", load_count - l0, 1);
      check("step_busy", busy, 0);
      check("step_cnt", instr_cnt, exp_cnt);
`endif

      // T4a: ready arrives on the last allowed FETCH cycle.
      imem_ready = 1'b0;
      run        = 1'b1;
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         check("t4_wait_req", {imem_req, ir_load}, 2'b10);
      end
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
      issue(OPC_OP, 3'b100, 1'b1, 1'b1, 1'b0, 3'd4);
      drain_to_idle();
      check("t4_late_cause", halt_cause, 0);

      // T4b: ready never arrives -> timeout halt.
      @(negedge clk);
      imem_ready = 1'b0;
      run        = 1'b1;
      l0         = load_count;
      n          = 0;
      for (int i = 0; i < 4 * TO + 8; i++) begin
         @(negedge clk);
         if (imem_req) n++;
      end
      check("t4_req_cycles", n, TO + 1);
      check("t4_cause", halt_cause, 2'b10);
      check("t4_busy", {busy, imem_req}, 2'b00);
      check("t4_loads", load_count - l0, 0);
      imem_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("t4_sticky", halt_cause, 2'b10);
      check("t4_sticky_loads", load_count - l0, 0);

      // T3: illegal opcode halts with no strobes and no retire.
      do_reset();
      run        = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      issue(OPC_BR, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rf_wr_en || pc_en) strobes++;
      end
      check("t3_strobes", strobes, 0);
      check("t3_cause", halt_cause, 2'b01);
      check("t3_busy", {busy, imem_req}, 2'b00);
      check("t3_cnt", instr_cnt, 0);

      // funct3=011 on OP is also illegal.
      do_reset();
      run        = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      issue(OPC_OP, 3'b011, 1'b0, 1'b0, 1'b0, 3'd0);
      repeat (4) @(negedge clk);
      check("t3_f3_cause", halt_cause, 2'b01);
      do_reset();

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
